// File: rtl/eth_pkg.sv
// Ethernet framing constants and types shared by the TX splitter and RX length checker.
package eth_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MAX_PAYLOAD = 16'd1500;
  localparam logic [CNT_W-1:0] MIN_PAYLOAD = 16'd46;
  localparam int HDR_BYTES = 14;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    DRAIN
  } rx_state_e;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    RUNT     = 3'd1,
    LEN_TYPE = 3'd2,
    MISMATCH = 3'd3,
    MAC_ERR  = 3'd4,
    OVERRUN  = 3'd5
  } rx_err_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_payload_len_chk_if.sv
// Byte-wide AXI-Stream link from the MAC receive path (FCS already stripped).
interface rx_payload_len_chk_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rx_hdr_parse.sv
// Counts the Ethernet header bytes and captures the big-endian length field
// carried in the last two header bytes.
module rx_hdr_parse
  import eth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat,
  input  logic             hdr_phase,
  input  logic             clear,
  input  logic [7:0]       tdata,
  input  logic             tlast,
  output logic [CNT_W-1:0] len_field,
  output logic [CNT_W-1:0] len_next,
  output logic             hdr_done,
  output logic             runt
);

  localparam logic [3:0] LEN_MSB_IDX = 4'(HDR_BYTES - 2);
  localparam logic [3:0] LEN_LSB_IDX = 4'(HDR_BYTES - 1);

  logic [3:0] hdr_cnt;
  logic       hdr_beat;

  assign hdr_beat = beat & hdr_phase;
  assign hdr_done = hdr_beat & (hdr_cnt == LEN_LSB_IDX);
  assign runt     = hdr_beat & tlast;

  // Lets the caller range-check the length on the same beat that completes it.
  assign len_next = hdr_done ? {len_field[15:8], tdata} : len_field;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt   <= '0;
      len_field <= '0;
    end else begin
      if (clear) begin
        hdr_cnt <= '0;
      end else if (hdr_beat) begin
        if (tlast || hdr_done) hdr_cnt <= '0;
        else                   hdr_cnt <= hdr_cnt + 4'd1;
      end
      if (hdr_beat && (hdr_cnt == LEN_MSB_IDX)) len_field[15:8] <= tdata;
      if (hdr_done)                             len_field[7:0]  <= tdata;
    end
  end

endmodule

// File: rtl/rx_payload_len_chk.sv
// Receive payload length checker: validates each frame's length field against the
// bytes actually received and debits good frames from a software-loaded byte budget.
module rx_payload_len_chk
  import eth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     expected_bytes,
  rx_payload_len_chk_if.slave  s_axis,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [2:0]           err_code,
  output logic [CNT_W-1:0]     payload_len,
  output logic [CNT_W-1:0]     remain,
  output logic                 done,
  output logic [CNT_W-1:0]     ok_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  rx_state_e        state, state_nxt;
  rx_err_e          pend, pend_nxt, fin_code;
  logic             fin, fin_ok, fin_err;
  logic             tready_q, beat, armed, hdr_phase;
  logic [CNT_W-1:0] pay_cnt, eff_len;
  logic [CNT_W-1:0] len_field, len_next;
  logic             hdr_done, runt;

  assign s_axis.tready = tready_q;
  assign beat          = s_axis.tvalid & tready_q;
  assign hdr_phase     = (state == IDLE) || (state == HDR);
  assign eff_len       = (len_field < MIN_PAYLOAD) ? MIN_PAYLOAD : len_field;

  rx_hdr_parse u_hdr_parse (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat      (beat),
    .hdr_phase (hdr_phase),
    .clear     (start),
    .tdata     (s_axis.tdata),
    .tlast     (s_axis.tlast),
    .len_field (len_field),
    .len_next  (len_next),
    .hdr_done  (hdr_done),
    .runt      (runt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (beat) state_nxt = s_axis.tlast ? IDLE : HDR;
      HDR: begin
        if (beat) begin
          if (s_axis.tlast)                    state_nxt = IDLE;
          else if (hdr_done && len_next > MAX_PAYLOAD) state_nxt = DRAIN;
          else if (hdr_done)                   state_nxt = PAY;
        end
      end
      PAY: begin
        if (beat) begin
          if (s_axis.tlast)                state_nxt = IDLE;
          else if (pay_cnt >= MAX_PAYLOAD) state_nxt = DRAIN;
        end
      end
      DRAIN: if (beat && s_axis.tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A restart abandons any partially received frame without reporting it.
    if (start) begin
      if (beat && s_axis.tlast)       state_nxt = IDLE;
      else if (state != IDLE || beat) state_nxt = DRAIN;
      else                            state_nxt = IDLE;
    end
  end

  always_comb begin
    fin      = 1'b0;
    fin_code = NONE;
    pend_nxt = pend;
    if (beat && s_axis.tlast && !start) begin
      if (state == DRAIN) begin
        fin      = (pend != NONE);
        fin_code = s_axis.tuser ? MAC_ERR : pend;
      end else begin
        fin = 1'b1;
        if (s_axis.tuser)                                fin_code = MAC_ERR;
        else if (runt)                                   fin_code = RUNT;
        else if ((pay_cnt + 16'd1) != eff_len)           fin_code = MISMATCH;
        else if (armed && (len_field > remain))          fin_code = OVERRUN;
        else                                             fin_code = NONE;
      end
    end
    if (start || (beat && s_axis.tlast))                      pend_nxt = NONE;
    else if (hdr_done && (len_next > MAX_PAYLOAD))            pend_nxt = LEN_TYPE;
    else if (state == PAY && beat && pay_cnt >= MAX_PAYLOAD)  pend_nxt = MISMATCH;
    fin_ok  = fin && (fin_code == NONE);
    fin_err = fin && (fin_code != NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_q    <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      payload_len <= '0;
      remain      <= '0;
      done        <= 1'b0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
      armed       <= 1'b0;
      pend        <= NONE;
      pay_cnt     <= '0;
    end else begin
      tready_q  <= 1'b1;
      frame_ok  <= fin_ok;
      frame_err <= fin_err;
      pend      <= pend_nxt;
      if (hdr_done)                 pay_cnt <= '0;
      else if (state == PAY && beat) pay_cnt <= pay_cnt + 16'd1;
      if (start) begin
        remain   <= expected_bytes;
        ok_cnt   <= '0;
        err_cnt  <= '0;
        err_code <= '0;
        done     <= (expected_bytes == '0);
        armed    <= (expected_bytes != '0);
      end else begin
        if (fin_err) begin
          err_code <= fin_code;
          err_cnt  <= sat_inc(err_cnt);
        end
        if (fin_ok) begin
          payload_len <= len_field;
          ok_cnt      <= sat_inc(ok_cnt);
          // The OVERRUN check guarantees len_field <= remain here.
          if (armed) begin
            remain <= remain - len_field;
            if (remain == len_field) begin
              done  <= 1'b1;
              armed <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
